uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_top transmitter between NUM_REQ byte producers using a valid/ready handshake per requester and round-robin grant. It can lock the grant across multi-byte packets, delimited by a per-requester last flag. It sequences each byte into the transmitter as a single tx_start pulse, waits for tx_done, and guards the transfer with a watchdog. It sits between the requesters and the uart_top tx_data/tx_start/tx_busy/tx_done pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DONE_TIMEOUT, 8192, max cycles from tx_start to tx_done before abort
LOCK_TIMEOUT, 1024, max cycles a locked grant waits idle for the next packet byte

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet (1 = release grant after it)
req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
uart_tx_data  out  8  byte to transmitter
uart_tx_start  out  1  one-cycle launch pulse to transmitter
uart_tx_busy  in  1  transmitter busy
uart_tx_done  in  1  one-cycle transmitter completion pulse
grant_valid  out  1  a requester currently owns the transmitter
grant_id  out  3  index of owning requester
timeout_err  out  1  one-cycle pulse on DONE_TIMEOUT abort

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0; uart_tx_start=0; uart_tx_data=0; grant_valid=0; grant_id=0; timeout_err=0; rr_ptr=0; lock=0; counters=0. Reset mid-byte drops uart_tx_start immediately. The byte already in the UART is not tracked.
- Requester rule: once req_valid[i] rises, it stays high with req_data and req_last stable until the handshake.
- Round-robin: the search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester wins. On release of grant g, rr_ptr=(g+1) mod NUM_REQ. Before any release, requester 0 has priority.
- FSM states and transitions:
  - IDLE: when any req_valid is high, register the winner into grant_id and set grant_valid=1 -> LAUNCH.
  - LAUNCH: req_ready[g] = req_valid[g] & ~uart_tx_busy (combinational; other ready bits are 0). On handshake, register the byte into uart_tx_data and lock = ~req_last[g] -> START. Otherwise stay.
  - START: uart_tx_start=1 for exactly this cycle; clear the watchdog -> WAIT_DONE.
  - WAIT_DONE: count cycles.
    - On uart_tx_done with lock=1 and req_valid[g]=1 -> LAUNCH.
    - On uart_tx_done with lock=1 and req_valid[g]=0 -> HOLD.
    - On uart_tx_done with lock=0 -> release -> IDLE.
    - If the count reaches DONE_TIMEOUT-1 without tx_done: pulse timeout_err, clear lock, release -> IDLE.
  - HOLD: count cycles. req_valid[g] -> LAUNCH. If the count reaches LOCK_TIMEOUT-1, clear lock and release -> IDLE (no error).
  - Release means grant_valid=0 and rr_ptr is updated on the same edge. grant_id keeps its last value.
- Latency:
  - From req_valid rising in IDLE with the transmitter idle, uart_tx_start asserts 2 cycles later (IDLE -> LAUNCH -> START).
  - A locked next byte starts 2 cycles after tx_done.
  - Release to new grant costs 1 IDLE cycle.
- Ignored or blocked events:
  - uart_tx_done outside WAIT_DONE is ignored.
  - Valids from other requesters are ignored while grant_valid=1.
  - uart_tx_busy high in LAUNCH stalls the handshake.
- Simultaneous events:
  - uart_tx_done and a watchdog expiry on the same cycle: done wins, no error.
  - A requester raising valid on the release cycle is considered in the following IDLE cycle.
- At most one uart_tx_start is issued per accepted byte. There is never more than one byte outstanding.

Test Plan:
1. Single requester: req 2 sends 0xA5 with last=1 (baud_divisor=32) -> one uart_tx_start 2 cycles after valid, with uart_tx_data=0xA5; loopback rx_data=0xA5; grant released after done; rr_ptr=3.
2. Fairness: reqs 0,1,3 valid continuously, each byte last=1 -> transmitted order 0,1,3,0,1,3; no requester is granted twice while another waits.
3. Packet lock: req 1 sends 0x11,0x22,0x33 (last on 0x33) while req 0 is valid -> all three bytes are transmitted before req 0's byte; grant_id stays 1 throughout.
4. Lock timeout: req 1 sends 0x44 with last=0, then drops valid -> after LOCK_TIMEOUT cycles in HOLD the grant is released and req 0 is served next; timeout_err stays 0.
5. Done timeout: uart_tx_done tied low -> timeout_err pulses exactly once, DONE_TIMEOUT cycles after uart_tx_start; FSM returns to IDLE.
6. Reset mid-transfer: assert reset_n low during WAIT_DONE -> all outputs are 0 immediately; after release, the pending req 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers. A grant can stay locked across a multi-byte packet (closed by
// req_last). Each byte is launched with a single tx_start pulse and guarded
// by a tx_done watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DONE_TIMEOUT = 8192,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_start,
    input  logic                 uart_tx_busy,
    input  logic                 uart_tx_done,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);

    // One counter serves both the done watchdog and the idle-lock timer.
    localparam int CNT_MAX = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_START,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [2:0]    rr_ptr;
    logic          lock;
    logic [CW-1:0] cnt;

    logic          g_valid, g_last;
    logic [7:0]    g_data;
    logic          win_found;
    logic [2:0]    win_id;
    logic          do_grant, do_accept, do_release, cnt_clr, cnt_inc;

    // Mux out the owning requester's handshake signals.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first valid at or above rr_ptr, else lowest valid (wrap).
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[i] && (3'(i) >= rr_ptr)) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[i]) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Next-state logic, launch strobes and datapath control.
    always_comb begin
        state_n       = state;
        req_ready     = '0;
        uart_tx_start = 1'b0;
        timeout_err   = 1'b0;
        do_grant      = 1'b0;
        do_accept     = 1'b0;
        do_release    = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    do_grant = 1'b1;
                    state_n  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Only the owner may handshake, and only when the UART can take it.
                if (g_valid && !uart_tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        req_ready[i] = (grant_id == 3'(i));
                    do_accept = 1'b1;
                    state_n   = S_START;
                end
            end
            S_START: begin
                uart_tx_start = 1'b1;
                cnt_clr       = 1'b1;
                state_n       = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // tx_done is checked first so it beats a same-cycle expiry.
                if (uart_tx_done) begin
                    if (lock && g_valid) begin
                        state_n = S_LAUNCH;
                    end else if (lock) begin
                        cnt_clr = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        do_release = 1'b1;
                        state_n    = S_IDLE;
                    end
                end else if (cnt == DONE_LAST) begin
                    timeout_err = 1'b1;
                    do_release  = 1'b1;
                    state_n     = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (g_valid) begin
                    state_n = S_LAUNCH;
                end else if (cnt == LOCK_LAST) begin
                    do_release = 1'b1;
                    state_n    = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Grant, lock, round-robin pointer, byte register and shared counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_valid  <= 1'b0;
            grant_id     <= 3'd0;
            rr_ptr       <= 3'd0;
            lock         <= 1'b0;
            uart_tx_data <= 8'h00;
            cnt          <= '0;
        end else begin
            if (do_grant) begin
                grant_valid <= 1'b1;
                grant_id    <= win_id;
            end
            if (do_accept) begin
                uart_tx_data <= g_data;
                lock         <= ~g_last;
            end
            if (do_release) begin
                grant_valid <= 1'b0;
                lock        <= 1'b0;
                rr_ptr      <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

endmodule
